// File: rtl/tri_rlmreg_arb.sv
// tri_rlmreg_arb: round-robin write arbiter for one shared WIDTH-bit config register.
// Rev 1.0 -- stage winner's data in IDLE, commit in WRITE, one-cycle ack afterwards.
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 5
`endif

module tri_rlmreg_arb #(
  parameter int REQ   = 4,
  parameter int WIDTH = 16,
  parameter     INIT  = 0,
  parameter int OWNW  = 2
) (
  input  logic [`NCLK_WIDTH-1:0] nclk,
  inout  wire                    vd,
  inout  wire                    gd,
  input  logic                   thold_b,
  input  logic [REQ-1:0]         req,
  input  logic [REQ*WIDTH-1:0]   wdata,
  output logic [REQ-1:0]         ack,
  output logic [WIDTH-1:0]       dout,
  output logic                   busy,
  output logic                   reg_act,
  output logic [OWNW-1:0]        last_owner
);

  localparam logic [0:0]      S_IDLE  = 1'b0;
  localparam logic [0:0]      S_WRITE = 1'b1;
  localparam logic [OWNW:0]   C_REQ   = (OWNW+1)'(REQ);
  localparam logic [OWNW-1:0] C_LAST  = OWNW'(REQ - 1);

  logic                   rst;
  logic                   unused_pins;
  logic [0:0]             state_q, state_d;
  logic [WIDTH-1:0]       dout_q, dout_d;
  logic [WIDTH-1:0]       stage_q, stage_d;
  logic [REQ-1:0]         ack_q, ack_d;
  logic [OWNW-1:0]        ptr_q, ptr_d;
  logic [OWNW-1:0]        win_q, win_d;
  logic [OWNW-1:0]        last_q, last_d;

  logic [REQ-1:0]         w_elig;
  logic [2*REQ-1:0]       w_dbl;
  logic [REQ-1:0]         w_rot;
  logic                   w_found;
  logic [OWNW:0]          w_sum;
  logic [OWNW-1:0]        w_winner;

  assign rst         = nclk[1];
  assign unused_pins = ^{nclk[`NCLK_WIDTH-1:2], vd, gd};

  // Rotate eligibility so bit 0 is the requester at ptr; the first set bit is the winner offset.
  assign w_elig = req & ~ack_q;
  assign w_dbl  = {w_elig, w_elig} >> ptr_q;
  assign w_rot  = w_dbl[REQ-1:0];

  always_comb begin
    w_found  = 1'b0;
    w_sum    = '0;
    w_winner = '0;
    for (int k = 0; k < REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, ptr_q} + (OWNW+1)'(k);
        if (w_sum >= C_REQ) begin
          w_sum = w_sum - C_REQ;
        end
        w_winner = w_sum[OWNW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    stage_d = stage_q;
    ack_d   = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (thold_b && w_found) begin
          stage_d = wdata[int'(w_winner)*WIDTH +: WIDTH];
          win_d   = w_winner;
          state_d = S_WRITE;
        end
      end
      default: begin
        if (thold_b) begin
          dout_d  = stage_q;
          ack_d   = REQ'(1) << win_q;
          last_d  = win_q;
          ptr_d   = (win_q == C_LAST) ? '0 : win_q + 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge nclk[0]) begin
    if (rst) begin
      state_q <= S_IDLE;
      dout_q  <= WIDTH'(INIT);
      stage_q <= '0;
      ack_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      stage_q <= stage_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  assign ack        = ack_q;
  assign dout       = dout_q;
  assign busy       = (state_q == S_WRITE);
  assign reg_act    = (state_q == S_WRITE) && thold_b;
  assign last_owner = last_q;

endmodule

`default_nettype wire

// File: tb/tb_tri_rlmreg_arb.sv
// tb_tri_rlmreg_arb: directed and random stimulus against a transaction-level arbiter model.
// Rev 1.0
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 5
`endif

module tb_tri_rlmreg_arb;

  localparam int          REQ   = 4;
  localparam int          WIDTH = 16;
  localparam int          OWNW  = 2;
  localparam logic [15:0] INITV = 16'hA5A5;

  logic                    clk;
  logic                    rst;
  logic [`NCLK_WIDTH-1:0]  nclk;
  wire                     vd;
  wire                     gd;
  logic                    thold_b;
  logic [REQ-1:0]          req;
  logic [REQ*WIDTH-1:0]    wdata;
  logic [REQ-1:0]          ack;
  logic [WIDTH-1:0]        dout;
  logic                    busy;
  logic                    reg_act;
  logic [OWNW-1:0]         last_owner;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: an outstanding write (owner, data) waiting to commit, plus the visible results.
  bit          m_pending;
  int          m_owner;
  logic [15:0] m_data;
  logic [15:0] m_dout;
  logic [3:0]  m_ack;
  int          m_next;
  int          m_last;

  assign nclk = {{(`NCLK_WIDTH-2){1'b0}}, rst, clk};
  assign vd   = 1'b1;
  assign gd   = 1'b0;

  tri_rlmreg_arb #(.REQ(REQ), .WIDTH(WIDTH), .INIT(INITV), .OWNW(OWNW)) dut (
    .nclk(nclk), .vd(vd), .gd(gd), .thold_b(thold_b), .req(req), .wdata(wdata),
    .ack(ack), .dout(dout), .busy(busy), .reg_act(reg_act), .last_owner(last_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] acked_now;
    if (rst) begin
      m_pending = 0; m_owner = 0; m_data = '0; m_dout = INITV;
      m_ack = '0; m_next = 0; m_last = 0;
    end else begin
      acked_now = '0;
      if (m_pending) begin
        if (thold_b) begin
          m_dout    = m_data;
          acked_now[m_owner] = 1'b1;
          m_last    = m_owner;
          m_next    = (m_owner + 1) % REQ;
          m_pending = 0;
        end
      end else if (thold_b) begin
        for (int k = 0; k < REQ; k++) begin
          int i;
          i = (m_next + k) % REQ;
          if (!m_pending && req[i] && !m_ack[i]) begin
            m_pending = 1;
            m_owner   = i;
            m_data    = wdata[i*WIDTH +: WIDTH];
          end
        end
      end
      m_ack = acked_now;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("dout", 64'(dout), 64'(m_dout));
    chk("ack", 64'(ack), 64'(m_ack));
    chk("busy", 64'(busy), 64'(m_pending));
    chk("reg_act", 64'(reg_act), 64'(m_pending && thold_b));
    chk("last_owner", 64'(last_owner), 64'(m_last));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int q_id[$];
    int q_cyc[$];
    rst = 1'b1; thold_b = 1'b1; req = '0; wdata = '0;
    m_pending = 0; m_owner = 0; m_data = '0; m_dout = INITV; m_ack = '0; m_next = 0; m_last = 0;

    // Reset state
    do_reset();
    chk("rst_dout", 64'(dout), 64'h0000_0000_0000_A5A5);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_owner", 64'(last_owner), 64'h0);

    // Single write from requester 2, req held through the ack
    req = 4'b0100; wdata[2*WIDTH +: WIDTH] = 16'h1234;
    cycle();
    chk("single_busy", 64'(busy), 64'h1);
    chk("single_regact", 64'(reg_act), 64'h1);
    cycle();
    chk("single_dout", 64'(dout), 64'h1234);
    chk("single_ack", 64'(ack), 64'b0100);
    chk("single_owner", 64'(last_owner), 64'h2);
    cycle();
    chk("single_nodouble", 64'(busy), 64'h0);
    req = '0;
    cycle();

    // Wrap: ptr is 3 after owner 2, so 3 beats 0
    req = 4'b1001; wdata[0 +: WIDTH] = 16'hAAAA; wdata[3*WIDTH +: WIDTH] = 16'h3333;
    cycle();
    cycle();
    chk("wrap_ack3", 64'(ack), 64'b1000);
    chk("wrap_dout3", 64'(dout), 64'h3333);
    req = 4'b0001;
    cycle();
    cycle();
    chk("wrap_ack0", 64'(ack), 64'b0001);
    chk("wrap_owner0", 64'(last_owner), 64'h0);
    req = '0;
    cycle();

    // Thold during WRITE, then thold in IDLE blocks grants
    req = 4'b0010; wdata[WIDTH +: WIDTH] = 16'h5A5A;
    cycle();
    thold_b = 1'b0;
    repeat (3) begin
      cycle();
      chk("hold_busy", 64'(busy), 64'h1);
      chk("hold_ack", 64'(ack), 64'h0);
      chk("hold_dout", 64'(dout), 64'hAAAA);
    end
    thold_b = 1'b1;
    cycle();
    chk("hold_commit_ack", 64'(ack), 64'b0010);
    chk("hold_commit_dout", 64'(dout), 64'h5A5A);
    req = '0;
    cycle();
    thold_b = 1'b0; req = 4'b0100;
    repeat (4) begin
      cycle();
      chk("hold_idle_nogrant", 64'(busy), 64'h0);
    end
    thold_b = 1'b1;
    cycle();
    cycle();
    req = '0;
    cycle();

    // Reset in the middle of a write
    req = 4'b0001; wdata[0 +: WIDTH] = 16'hBEEF;
    cycle();
    chk("midrst_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = '0;
    chk("midrst_dout", 64'(dout), 64'hA5A5);
    chk("midrst_busy0", 64'(busy), 64'h0);
    cycle();
    chk("midrst_noack", 64'(ack), 64'h0);
    chk("midrst_dout2", 64'(dout), 64'hA5A5);

    // Round robin with all requesters active
    do_reset();
    for (int i = 0; i < REQ; i++) wdata[i*WIDTH +: WIDTH] = 16'(16'h1000 + i);
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < REQ; i++) req[i] = !m_ack[i];
      cycle();
      for (int i = 0; i < REQ; i++) begin
        if (ack[i]) begin
          q_id.push_back(i);
          q_cyc.push_back(c);
        end
      end
    end
    chk("rr_count", 64'(q_id.size() >= 5), 64'h1);
    if (q_id.size() >= 5) begin
      for (int n = 0; n < 5; n++) chk("rr_order", 64'(q_id[n]), 64'(n % REQ));
      for (int n = 1; n < 5; n++) chk("rr_spacing", 64'(q_cyc[n] - q_cyc[n-1]), 64'h2);
    end
    req = '0;
    cycle();

    // Random traffic following the requester protocol
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < REQ; i++) begin
        if (m_ack[i]) begin
          if ($urandom_range(1, 0) == 1) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          wdata[i*WIDTH +: WIDTH] = 16'($urandom);
        end
      end
      thold_b = ($urandom_range(4, 0) != 0);
      rst     = ($urandom_range(99, 0) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
